// File: rtl/vga_pkg.sv
// Shared constants and the sideband record that travels alongside each pixel
// from coordinate sampling to the font ROM stage.
package vga_pkg;

  localparam int H_TILES          = 80;
  localparam int V_TILES          = 30;
  localparam int H_ACTIVE         = 640;
  localparam int V_ACTIVE         = 480;
  localparam int CHAR_W           = 8;
  localparam int CHAR_H           = 16;
  localparam int CURSOR_FIRST_ROW = 14;

  typedef struct packed {
    logic       qact;
    logic [1:0] slot;
    logic [3:0] glyph_row;
    logic [2:0] glyph_col;
    logic       hit;
    logic       hsync;
    logic       vsync;
  } sideband_t;

  // Syncs are active-low, so their idle value is 1.
  localparam sideband_t SB_RESET = '{
    qact:      1'b0,
    slot:      2'd0,
    glyph_row: 4'd0,
    glyph_col: 3'd0,
    hit:       1'b0,
    hsync:     1'b1,
    vsync:     1'b1
  };

endpackage

// File: rtl/vga_tile_fetch_if.sv
// Signal bundle between the sync generator / screen buffer / font stage and
// the tile fetcher; slave is the fetcher's view.
interface vga_tile_fetch_if #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 28,
  parameter int SINGLE_DATA = 7
);

  logic [9:0]             hcount_i;
  logic [9:0]             vcount_i;
  logic                   active_i;
  logic                   hsync_i;
  logic                   vsync_i;
  logic [6:0]             cursor_x_i;
  logic [4:0]             cursor_y_i;
  logic                   cursor_en_i;
  logic [ADDR_WIDTH-1:0]  vr_addr_o;
  logic [DATA_WIDTH-1:0]  dout_i;
  logic [SINGLE_DATA-1:0] char_o;
  logic [3:0]             glyph_row_o;
  logic [2:0]             glyph_col_o;
  logic                   cursor_o;
  logic                   active_o;
  logic                   hsync_o;
  logic                   vsync_o;

  modport slave (
    input  hcount_i, vcount_i, active_i, hsync_i, vsync_i,
    input  cursor_x_i, cursor_y_i, cursor_en_i, dout_i,
    output vr_addr_o, char_o, glyph_row_o, glyph_col_o,
    output cursor_o, active_o, hsync_o, vsync_o
  );

  modport master (
    output hcount_i, vcount_i, active_i, hsync_i, vsync_i,
    output cursor_x_i, cursor_y_i, cursor_en_i, dout_i,
    input  vr_addr_o, char_o, glyph_row_o, glyph_col_o,
    input  cursor_o, active_o, hsync_o, vsync_o
  );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a synchronous reset value; DEPTH >= 1.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= RST_VAL;
    end else begin
      taps[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign q_o = taps[DEPTH-1];

endmodule

// File: rtl/vga_tile_fetch.sv
// Turns pixel coordinates into screen-buffer word addresses and unpacks the
// returned word into one character code per pixel, 3 cycles after sampling.
module vga_tile_fetch
  import vga_pkg::*;
#(
  parameter int H_TILES      = vga_pkg::H_TILES,
  parameter int V_TILES      = vga_pkg::V_TILES,
  parameter int DATA_WIDTH   = 28,
  parameter int SINGLE_DATA  = 7,
  parameter int ADDR_WIDTH   = 10,
  parameter int BLINK_FRAMES = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  vga_tile_fetch_if.slave  bus
);

  localparam int H_LIM = H_TILES * CHAR_W;
  localparam int V_LIM = V_TILES * CHAR_H;
  localparam int SLOTS = DATA_WIDTH / SINGLE_DATA;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [6:0]             col_p0;
  logic [5:0]             row_p0;
  logic [11:0]            tile_p0;
  logic                   vld_p0;
  sideband_t              sb_p0;
  sideband_t              sb_p2;
  logic [SINGLE_DATA-1:0] char_sel_p2;

  logic                   vsync_q;
  logic [CNT_W-1:0]       frame_cnt;
  logic                   blink_on;

  // Stage 0: qualify the coordinate and form the tile index
  assign col_p0  = bus.hcount_i[9:3];
  assign row_p0  = bus.vcount_i[9:4];
  assign vld_p0  = bus.active_i && (bus.hcount_i < 10'(H_LIM)) &&
                   (bus.vcount_i < 10'(V_LIM));
  assign tile_p0 = 12'(row_p0) * 12'(H_TILES) + 12'(col_p0);

  always_comb begin
    sb_p0           = SB_RESET;
    sb_p0.qact      = vld_p0;
    sb_p0.slot      = tile_p0[1:0];
    sb_p0.glyph_row = bus.vcount_i[3:0];
    sb_p0.glyph_col = bus.hcount_i[2:0];
    sb_p0.hit       = bus.cursor_en_i && (col_p0 == bus.cursor_x_i) &&
                      (row_p0 == 6'(bus.cursor_y_i)) &&
                      (bus.vcount_i[3:0] >= 4'(CURSOR_FIRST_ROW));
    sb_p0.hsync     = bus.hsync_i;
    sb_p0.vsync     = bus.vsync_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) bus.vr_addr_o <= '0;
    else       bus.vr_addr_o <= vld_p0 ? ADDR_WIDTH'(tile_p0 >> 2) : '0;
  end

  // Stages 0..1: sideband waits out the buffer read
  vga_delay_line #(
    .WIDTH   ($bits(sideband_t)),
    .DEPTH   (2),
    .RST_VAL (SB_RESET)
  ) u_sideband (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (sb_p0),
    .q_o   (sb_p2)
  );

  // Cursor blink: one count per vsync falling edge, toggle on wrap
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vsync_q   <= 1'b1;
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      vsync_q <= bus.vsync_i;
      if (vsync_q && !bus.vsync_i) begin
        if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_on  <= !blink_on;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Stage 2: pick the character out of the returned word
  always_comb begin
    char_sel_p2 = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (sb_p2.slot == 2'(k)) char_sel_p2 = bus.dout_i[k*SINGLE_DATA +: SINGLE_DATA];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.char_o      <= '0;
      bus.glyph_row_o <= '0;
      bus.glyph_col_o <= '0;
      bus.cursor_o    <= 1'b0;
      bus.active_o    <= 1'b0;
      bus.hsync_o     <= 1'b1;
      bus.vsync_o     <= 1'b1;
    end else begin
      bus.char_o      <= sb_p2.qact ? char_sel_p2 : '0;
      bus.glyph_row_o <= sb_p2.glyph_row;
      bus.glyph_col_o <= sb_p2.glyph_col;
      bus.cursor_o    <= sb_p2.qact && sb_p2.hit && blink_on;
      bus.active_o    <= sb_p2.qact;
      bus.hsync_o     <= sb_p2.hsync;
      bus.vsync_o     <= sb_p2.vsync;
    end
  end

endmodule

// File: tb/tb_vga_tile_fetch.sv
// Directed bench for vga_tile_fetch: vector tables streamed one per cycle,
// plus hand-written blink and mid-frame reset sequences.
module tb_vga_tile_fetch;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  vga_tile_fetch_if #(.ADDR_WIDTH(10), .DATA_WIDTH(28), .SINGLE_DATA(7)) bus();

  vga_tile_fetch #(
    .H_TILES(80), .V_TILES(30), .DATA_WIDTH(28), .SINGLE_DATA(7),
    .ADDR_WIDTH(10), .BLINK_FRAMES(2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Screen buffer model: one-cycle read; word a holds codes 4a..4a+3 (mod 128).
  logic        fixed_mode = 1'b1;
  logic [27:0] fixed_word;
  assign fixed_word = {7'h44, 7'h43, 7'h42, 7'h41};

  function automatic logic [27:0] word_of(logic [9:0] a);
    logic [11:0] b;
    b = {a, 2'b00};
    return {7'(b + 12'd3), 7'(b + 12'd2), 7'(b + 12'd1), 7'(b)};
  endfunction

  always @(posedge clk) bus.dout_i <= fixed_mode ? fixed_word : word_of(bus.vr_addr_o);

  typedef struct {
    int h, v;
    bit act, hs, vs;
    int cx, cy;
    bit cen;
    int e_addr, e_char, e_row, e_col;
    bit e_cur, e_act;
  } vec_t;

  vec_t tbl[$];
  int applied = 0;
  int errs    = 0;

  task automatic chk(string nm, int got, int exp);
    applied++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic add(int h, int v, bit act, bit hs, int cx, int cy, bit cen,
                     int e_addr, int e_char, bit e_cur);
    vec_t t;
    t.h = h; t.v = v; t.act = act; t.hs = hs; t.vs = 1'b1;
    t.cx = cx; t.cy = cy; t.cen = cen;
    t.e_addr = e_addr; t.e_char = e_char;
    t.e_row = v % 16; t.e_col = h % 8;
    t.e_cur = e_cur; t.e_act = (e_addr != 0) || (e_char != 0) || (act && h < 640 && v < 480);
    tbl.push_back(t);
  endtask

  task automatic drive(int h, int v, bit act, bit hs, bit vs, int cx, int cy, bit cen);
    bus.hcount_i    = 10'(h);
    bus.vcount_i    = 10'(v);
    bus.active_i    = act;
    bus.hsync_i     = hs;
    bus.vsync_i     = vs;
    bus.cursor_x_i  = 7'(cx);
    bus.cursor_y_i  = 5'(cy);
    bus.cursor_en_i = cen;
  endtask

  task automatic idle(bit vs);
    drive(0, 0, 1'b0, 1'b1, vs, 0, 0, 1'b0);
  endtask

  task automatic run_table(string tag);
    int n;
    vec_t e;
    n = tbl.size();
    for (int i = 0; i < n + 3; i++) begin
      @(negedge clk);
      if (i >= 1 && i - 1 < n)
        chk($sformatf("%s addr[%0d]", tag, i - 1), int'(bus.vr_addr_o), tbl[i-1].e_addr);
      if (i >= 3) begin
        e = tbl[i-3];
        chk($sformatf("%s char[%0d]", tag, i - 3), int'(bus.char_o), e.e_char);
        chk($sformatf("%s row[%0d]", tag, i - 3), int'(bus.glyph_row_o), e.e_row);
        chk($sformatf("%s col[%0d]", tag, i - 3), int'(bus.glyph_col_o), e.e_col);
        chk($sformatf("%s cursor[%0d]", tag, i - 3), int'(bus.cursor_o), int'(e.e_cur));
        chk($sformatf("%s active[%0d]", tag, i - 3), int'(bus.active_o), int'(e.e_act));
        chk($sformatf("%s hsync[%0d]", tag, i - 3), int'(bus.hsync_o), int'(e.hs));
        chk($sformatf("%s vsync[%0d]", tag, i - 3), int'(bus.vsync_o), int'(e.vs));
      end
      if (i < n) drive(tbl[i].h, tbl[i].v, tbl[i].act, tbl[i].hs, tbl[i].vs,
                       tbl[i].cx, tbl[i].cy, tbl[i].cen);
      else       idle(1'b1);
    end
    tbl.delete();
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, " addr"},   int'(bus.vr_addr_o),   0);
    chk({tag, " char"},   int'(bus.char_o),      0);
    chk({tag, " row"},    int'(bus.glyph_row_o), 0);
    chk({tag, " col"},    int'(bus.glyph_col_o), 0);
    chk({tag, " cursor"}, int'(bus.cursor_o),    0);
    chk({tag, " active"}, int'(bus.active_o),    0);
    chk({tag, " hsync"},  int'(bus.hsync_o),     1);
    chk({tag, " vsync"},  int'(bus.vsync_o),     1);
  endtask

  // Cursor cell (5,2), underline row 46: result appears on the third negedge.
  task automatic cur_probe(string nm, bit exp);
    @(negedge clk); drive(40, 46, 1'b1, 1'b1, 1'b1, 5, 2, 1'b1);
    @(negedge clk); idle(1'b1);
    @(negedge clk);
    @(negedge clk);
    chk(nm, int'(bus.cursor_o), int'(exp));
  endtask

  task automatic vs_pulse();
    @(negedge clk); idle(1'b0);
    @(negedge clk); idle(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish within budget");
    $fatal(1);
  end

  initial begin
    idle(1'b1);
    repeat (3) @(negedge clk);
    chk_reset_state("init");
    rst = 1'b0;

    // Slot sweep with a fixed word; hsync driven low for the second half.
    for (int h = 0; h < 32; h++) add(h, 0, 1'b1, (h < 16), 0, 0, 1'b0, 0, 'h41 + h / 8, 1'b0);
    run_table("slot");

    fixed_mode = 1'b0;
    add(H_ACTIVE - 1, V_ACTIVE - 1, 1'b1, 1'b1, 0, 0, 1'b0, 599, 'h5F, 1'b0);
    add(8,   0,   1'b1, 1'b1, 0, 0, 1'b0, 0,  1,  1'b0);
    add(100, 37,  1'b1, 1'b0, 0, 0, 1'b0, 43, 44, 1'b0);
    add(640, 10,  1'b1, 1'b1, 0, 0, 1'b0, 0,  0,  1'b0);
    add(10,  480, 1'b1, 1'b1, 0, 0, 1'b0, 0,  0,  1'b0);
    add(300, 200, 1'b0, 1'b0, 0, 0, 1'b0, 0,  0,  1'b0);
    add(800, 46,  1'b1, 1'b1, 100, 2, 1'b1, 0, 0, 1'b0);
    run_table("map");

    // Cursor at (5,2): only pixel rows 14..15 of the cell, only columns 40..47.
    for (int h = 40; h < 48; h++) add(h, 45, 1'b1, 1'b1, 5, 2, 1'b1, 41, 37, 1'b0);
    add(39, 46, 1'b1, 1'b1, 5, 2, 1'b1, 41, 36, 1'b0);
    for (int h = 40; h < 48; h++) add(h, 46, 1'b1, 1'b1, 5, 2, 1'b1, 41, 37, 1'b1);
    add(48, 46, 1'b1, 1'b1, 5, 2, 1'b1, 41, 38, 1'b0);
    for (int h = 40; h < 48; h++) add(h, 46, 1'b1, 1'b1, 5, 2, 1'b0, 41, 37, 1'b0);
    run_table("cursor");

    // Blink with two frames per half-period.
    cur_probe("blink start", 1'b1);
    vs_pulse();
    cur_probe("blink after 1 edge", 1'b1);
    vs_pulse();
    cur_probe("blink after 2 edges", 1'b0);
    vs_pulse();
    cur_probe("blink after 3 edges", 1'b0);
    vs_pulse();
    cur_probe("blink after 4 edges", 1'b1);

    // Mid-frame reset with the pixel stream still running.
    @(negedge clk); drive(100, 37, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre-reset active", int'(bus.active_o), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midreset");
    rst = 1'b0;
    @(negedge clk);
    chk("release+1 addr",   int'(bus.vr_addr_o), 43);
    chk("release+1 active", int'(bus.active_o),  0);
    @(negedge clk);
    chk("release+2 active", int'(bus.active_o),  0);
    chk("release+2 char",   int'(bus.char_o),    0);
    @(negedge clk);
    chk("release+3 active", int'(bus.active_o),  1);
    chk("release+3 char",   int'(bus.char_o),    44);
    chk("release+3 hsync",  int'(bus.hsync_o),   0);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end

endmodule
